// File: rtl/pipe_share_arbiter_if.sv
// Requester/pipeline bundle for pipe_share_arbiter: request side, shared pipeline side, response side.
interface pipe_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic                     flush;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         pipe_in;
    logic                     pipe_in_valid;
    logic [WIDTH-1:0]         pipe_out;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]         resp_data;

    modport master (
        output req, req_data, flush, pipe_out,
        input  gnt, pipe_in, pipe_in_valid, resp_valid, resp_data
    );

    modport slave (
        input  req, req_data, flush, pipe_out,
        output gnt, pipe_in, pipe_in_valid, resp_valid, resp_data
    );
endinterface

// File: rtl/pipe_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency external pipeline between NUM_REQ requesters.
// Define PIPE_SHARE_BURST_EN to let a winner keep the pipeline for up to BURST consecutive grants.
module pipe_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 3,
    parameter int BURST   = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    pipe_share_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    typedef logic [PTR_W-1:0] idx_t;

    if (NUM_REQ < 2 || NUM_REQ > 16 || LATENCY < 1 || BURST < 1) begin : g_param_check
        $error("pipe_share_arbiter: parameter out of range");
    end

    // (base + off) mod NUM_REQ for off < NUM_REQ; NUM_REQ need not be a power of two.
    function automatic idx_t wrap_add(idx_t base, int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(NUM_REQ)) sum -= 32'(NUM_REQ);
        return idx_t'(sum);
    endfunction

    idx_t               ptr;
    idx_t               ptr_nxt;
    logic               rr_hit;
    idx_t               rr_idx;
    logic               grant_any;
    idx_t               grant_idx;
    logic [LATENCY-1:0] stg_valid;
    idx_t               stg_tag [LATENCY];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rr_hit && bus.req[wrap_add(ptr, i)]) begin
                rr_hit = 1'b1;
                rr_idx = wrap_add(ptr, i);
            end
        end
    end

`ifdef PIPE_SHARE_BURST_EN
    localparam int CNT_W = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST);

    typedef enum logic {ST_IDLE, ST_BURST} burst_state_t;

    burst_state_t     state, state_nxt;
    idx_t             owner, owner_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             keep;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            owner <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            count <= count_nxt;
        end
    end

    // Owner keeps the grant while it still requests and has budget; otherwise normal round-robin.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        state_nxt = ST_IDLE;
        owner_nxt = owner;
        count_nxt = '0;
        keep      = (state == ST_BURST) && bus.req[owner] && (count < BURST_MAX);
        if (reset_n && !bus.flush) begin
            if (keep) begin
                grant_any = 1'b1;
                grant_idx = owner;
                state_nxt = ST_BURST;
                count_nxt = count + 1'b1;
            end else if (rr_hit) begin
                grant_any = 1'b1;
                grant_idx = rr_idx;
                state_nxt = ST_BURST;
                owner_nxt = rr_idx;
                count_nxt = CNT_W'(1);
            end
        end
    end
`else
    always_comb begin
        grant_any = reset_n && !bus.flush && rr_hit;
        grant_idx = rr_idx;
    end
`endif

    assign ptr_nxt = grant_any ? wrap_add(grant_idx, 1) : ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            stg_valid <= '0;
            // NOTE: the tag stages are a short shift register, not a RAM, so they are reset too.
            for (int i = 0; i < LATENCY; i++) stg_tag[i] <= '0;
        end else begin
            ptr          <= ptr_nxt;
            stg_valid[0] <= grant_any;
            stg_tag[0]   <= grant_idx;
            for (int i = 1; i < LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1] && !bus.flush;
                stg_tag[i]   <= stg_tag[i-1];
            end
        end
    end

    always_comb begin
        bus.gnt = '0;
        if (grant_any) bus.gnt[grant_idx] = 1'b1;
    end

    assign bus.pipe_in_valid = grant_any;
    assign bus.pipe_in       = grant_any ? bus.req_data[32'(grant_idx)*WIDTH +: WIDTH] : '0;

    // An operation emerging during a flush cycle is discarded along with the rest.
    always_comb begin
        bus.resp_valid = '0;
        if (stg_valid[LATENCY-1] && !bus.flush) bus.resp_valid[stg_tag[LATENCY-1]] = 1'b1;
    end

    assign bus.resp_data = bus.pipe_out;
endmodule

// File: doc/pipe_share_arbiter.md
PIPE_SHARE_ARBITER -- requirements
Module: pipe_share_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter WIDTH, default 8, data width of the shared pipeline.
REQ-003 SHALL have parameter LATENCY, default 3, fixed latency of the shared external pipeline (>= 1).
REQ-004 SHALL have parameter BURST, default 4, maximum consecutive grants to one requester; used only with PIPE_SHARE_BURST_EN.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester request; bit k belongs to requester k.
REQ-008 SHALL have port req_data  input  NUM_REQ*WIDTH  requester k data at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port flush  input  1  discards all in-flight operations.
REQ-010 SHALL have port gnt  output  NUM_REQ  one-hot or zero grant, combinational.
REQ-011 SHALL have port pipe_in  output  WIDTH  data to the shared pipeline, combinational.
REQ-012 SHALL have port pipe_in_valid  output  1  pipe_in carries a granted operation.
REQ-013 SHALL have port pipe_out  input  WIDTH  shared pipeline result, LATENCY cycles after pipe_in.
REQ-014 SHALL have port resp_valid  output  NUM_REQ  one-hot or zero; result for requester k is on resp_data.
REQ-015 SHALL have port resp_data  output  WIDTH  equals pipe_out, passed through combinationally.

Function
REQ-016 SHALL grant at most one requester per cycle; gnt[k] = 1 only when req[k] = 1.
REQ-017 SHALL select round-robin: search starts at pointer ptr and wraps NUM_REQ-1 -> 0.
REQ-018 SHALL set ptr to (k+1) mod NUM_REQ on the clock edge ending a cycle that granted k; with no grant, ptr holds.
REQ-019 SHALL drive pipe_in = req_data of the granted requester; pipe_in_valid = |gnt; pipe_in = 0 when there is no grant.
REQ-020 SHALL track in-flight operations in an internal LATENCY-stage shift register of {valid, tag}, advancing every cycle without stall.
REQ-021 SHALL assert resp_valid[k] exactly LATENCY cycles after the cycle in which gnt[k] was asserted, at most one bit at a time.
REQ-022 SHALL, while flush = 1, force gnt = 0 and pipe_in_valid = 0, and clear every stage valid on that edge; no resp_valid arises from operations issued before or during flush.
REQ-023 SHALL, when flush and req coincide, drop the request without updating ptr; the requester retries in a later cycle.
REQ-024 SHALL accept a grant in every cycle (full throughput); back-to-back grants to different requesters produce back-to-back responses in grant order.

Reset
REQ-025 SHALL, on reset_n low, immediately clear ptr to 0, all stage valids and tags to 0, burst state to IDLE and burst count to 0.
REQ-026 SHALL hold gnt = 0, pipe_in_valid = 0, pipe_in = 0 and resp_valid = 0 while reset_n is low, regardless of req.
REQ-027 SHALL discard operations in flight when reset is asserted mid-operation; none produce resp_valid after release.

Configuration
REQ-028 SHALL, with macro PIPE_SHARE_BURST_EN defined, implement an FSM with states IDLE and BURST: a grant to k in IDLE enters BURST(owner = k, count = 1); in BURST, k keeps the grant while req[k] = 1 and count < BURST, incrementing count; the FSM returns to IDLE and ptr = owner+1 when req[owner] drops, count reaches BURST, or flush occurs.
REQ-029 SHALL, without PIPE_SHARE_BURST_EN, contain no burst state and perform single-grant round-robin per REQ-017/REQ-018.

Verification (NUM_REQ=4, WIDTH=8, LATENCY=3, BURST=4)
REQ-030 SHALL check: reset release, req=4'b1111 held, req_data k = 8'h10+k -> gnt 0001,0010,0100,1000,0001; resp_valid follows 3 cycles later; resp_data matches pipe_out.
REQ-031 SHALL check: req=4'b0100 alone for 3 cycles -> gnt 0100 every cycle, ptr=3; resp_valid[2] on cycles 3..5.
REQ-032 SHALL check: grants on cycles 0,1, flush on cycle 2 with req=4'b0001 -> gnt=0 on cycle 2, no resp_valid on cycles 3..5, ptr unchanged.
REQ-033 SHALL check: reset_n low on cycle 1 after a grant on cycle 0 -> outputs 0 immediately; no resp_valid after release; first post-reset grant starts from requester 0.
REQ-034 SHALL check (with PIPE_SHARE_BURST_EN): req=4'b0011 held -> gnt 0001 x4, then 0010 x4, then 0001; without the macro the same stimulus alternates 0001,0010.
